// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the CPU-side Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts strobe cycles without a slave response and
// produces a one-cycle abort, then blocks the strobe for one more cycle.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,   // granted master has cyc&stb up
  input  logic resp,     // slave ack/err/rty this cycle
  output logic abort_o,  // one-cycle abort pulse
  output logic block_o   // strobe must be held low this cycle
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign abort_o = 1'b0;
      assign block_o = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;
      logic          hold_q;
      logic          inc;

      // The hold cycle after an abort looks like stb=0, so it clears the count.
      assign inc     = active & ~hold_q & ~resp;
      assign abort_o = inc & (cnt == LIMIT);
      assign block_o = abort_o | hold_q;

      // Saturating stall counter and post-abort strobe hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          hold_q <= 1'b0;
        end else begin
          hold_q <= abort_o;
          if (!inc || abort_o)       cnt <= '0;
          else if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_cpu_bus_arbiter.sv
// Round-robin merge of the CPU ibus/dbus Wishbone masters onto one slave
// port. Grant is held for the whole cyc so bursts are never split.
module wb_cpu_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [AW-1:0]   ibus_adr_i,
  input  logic [DW-1:0]   ibus_dat_i,
  input  logic [DW/8-1:0] ibus_sel_i,
  input  logic            ibus_we_i,
  input  logic            ibus_cyc_i,
  input  logic            ibus_stb_i,
  input  logic [2:0]      ibus_cti_i,
  input  logic [1:0]      ibus_bte_i,
  output logic [DW-1:0]   ibus_dat_o,
  output logic            ibus_ack_o,
  output logic            ibus_err_o,
  output logic            ibus_rty_o,
  input  logic [AW-1:0]   dbus_adr_i,
  input  logic [DW-1:0]   dbus_dat_i,
  input  logic [DW/8-1:0] dbus_sel_i,
  input  logic            dbus_we_i,
  input  logic            dbus_cyc_i,
  input  logic            dbus_stb_i,
  input  logic [2:0]      dbus_cti_i,
  input  logic [1:0]      dbus_bte_i,
  output logic [DW-1:0]   dbus_dat_o,
  output logic            dbus_ack_o,
  output logic            dbus_err_o,
  output logic            dbus_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic            timeout_o
);

  typedef struct packed {
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
  } wb_req_t;

  wb_req_t    ireq, dreq, sreq;
  arb_state_e state_q, state_d;
  logic       last_q;
  logic       gnt_i, gnt_d;
  logic       active, resp, abort, block;

  assign ireq = '{adr: ibus_adr_i, dat: ibus_dat_i, sel: ibus_sel_i, we: ibus_we_i,
                  cyc: ibus_cyc_i, stb: ibus_stb_i, cti: ibus_cti_i, bte: ibus_bte_i};
  assign dreq = '{adr: dbus_adr_i, dat: dbus_dat_i, sel: dbus_sel_i, we: dbus_we_i,
                  cyc: dbus_cyc_i, stb: dbus_stb_i, cti: dbus_cti_i, bte: dbus_bte_i};

  // Grant state and round-robin history; last grant is recorded on entry.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GNT_I)      last_q <= GRANT_I;
      else if (state_q == IDLE && state_d == GNT_D) last_q <= GRANT_D;
    end
  end

  // Next grant: ties go to whoever was not served last; release always via IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ibus_cyc_i && dbus_cyc_i) state_d = (last_q == GRANT_I) ? GNT_D : GNT_I;
        else if (ibus_cyc_i)          state_d = GNT_I;
        else if (dbus_cyc_i)          state_d = GNT_D;
      end
      GNT_I:   if (!ibus_cyc_i) state_d = IDLE;
      GNT_D:   if (!dbus_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  // Request mux: granted master passes straight through, nothing in IDLE.
  always_comb begin
    sreq = '0;
    if (gnt_i)      sreq = ireq;
    else if (gnt_d) sreq = dreq;
  end

  assign active  = sreq.cyc & sreq.stb;
  assign resp    = s_ack_i | s_err_i | s_rty_i;

  assign s_adr_o = sreq.adr;
  assign s_dat_o = sreq.dat;
  assign s_sel_o = sreq.sel;
  assign s_we_o  = sreq.we;
  assign s_cti_o = sreq.cti;
  assign s_bte_o = sreq.bte;
  assign s_cyc_o = sreq.cyc;
  assign s_stb_o = active & ~block;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .active  (active),
    .resp    (resp),
    .abort_o (abort),
    .block_o (block)
  );

  // Response demux: only the granted master sees the slave; a watchdog abort
  // is reported as a bus error.
  assign ibus_ack_o = gnt_i & s_ack_i;
  assign ibus_err_o = gnt_i & (s_err_i | abort);
  assign ibus_rty_o = gnt_i & s_rty_i;
  assign dbus_ack_o = gnt_d & s_ack_i;
  assign dbus_err_o = gnt_d & (s_err_i | abort);
  assign dbus_rty_o = gnt_d & s_rty_i;

  assign ibus_dat_o = ibus_ack_o ? s_dat_i : '0;
  assign dbus_dat_o = dbus_ack_o ? s_dat_i : '0;
  assign timeout_o  = abort;

endmodule
